tr_mux_seq: RTL and testbench

//  Multi-channel transfer multiplexer with a registered, self-sequencing select.
//  N_CH channels share one select index. A started burst walks LEN beats from a start index, wrapping modulo LEN_TRANSFER.

---
 rtl/tr_mux_pkg.sv | 23 ++
 rtl/tr_mux_sel_ctr.sv | 40 ++++
 rtl/tr_mux_seq.sv | 140 ++++++++++++++
 tb/tb_tr_mux_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tr_mux_pkg.sv
// Shared types and default sizing for the transfer multiplexer (tr_mux_seq and tr_mux_sel_ctr).
package tr_mux_pkg;

  localparam int I_WIDTH          = 8;
  localparam int F_WIDTH          = 8;
  localparam int DW               = I_WIDTH + F_WIDTH;
  localparam int N_CH             = 4;
  localparam int LEN_TRANSFER     = 10;
  localparam int MAX_LEN_TRANSFER = 10;
  localparam int CNT_WIDTH        = 8;

  // A single-entry select still needs one bit to hold index 0.
  function automatic int sel_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  localparam int SEL_MUX_TR_WIDTH = sel_width(MAX_LEN_TRANSFER);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  typedef logic signed [DW-1:0] data_t;

endpackage

// File: rtl/tr_mux_sel_ctr.sv
// Select index register (load / increment with wrap at LEN-1) plus the remaining-beat counter.
module tr_mux_sel_ctr
  import tr_mux_pkg::*;
#(
  parameter int SEL_W = SEL_MUX_TR_WIDTH,
  parameter int CNT_W = CNT_WIDTH,
  parameter int LEN   = LEN_TRANSFER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_sel,
  input  logic             load_cnt,
  input  logic             step,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [CNT_W-1:0] len_in,
  output logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      remaining <= '0;
    end else begin
      if (load_sel) begin
        sel <= sel_in;
      end else if (step) begin
        sel <= (sel == LAST_SEL) ? '0 : sel + 1'b1;
      end
      if (load_cnt) begin
        remaining <= len_in;
      end else if (step) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tr_mux_seq.sv
// Multi-channel transfer mux with a self-sequencing registered select (IDLE/RUN/DONE FSM).
// Optional range checking of loaded/start select values: define TR_MUX_RANGE_CHECK_EN.
module tr_mux_seq
  import tr_mux_pkg::*;
#(
  parameter int I_WIDTH          = tr_mux_pkg::I_WIDTH,
  parameter int F_WIDTH          = tr_mux_pkg::F_WIDTH,
  parameter int N_CH             = tr_mux_pkg::N_CH,
  parameter int LEN_TRANSFER     = tr_mux_pkg::LEN_TRANSFER,
  parameter int MAX_LEN_TRANSFER = tr_mux_pkg::MAX_LEN_TRANSFER,
  parameter int SEL_MUX_TR_WIDTH = sel_width(MAX_LEN_TRANSFER),
  parameter int CNT_WIDTH        = tr_mux_pkg::CNT_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic signed [I_WIDTH+F_WIDTH-1:0]  tr_data_i [N_CH][LEN_TRANSFER],
  input  logic        [SEL_MUX_TR_WIDTH-1:0] sel_mux_tr_i,
  input  logic                               sel_mux_tr_ld_i,
  input  logic                               start_i,
  input  logic        [CNT_WIDTH-1:0]        len_i,
  input  logic                               abort_i,
  input  logic                               ready_i,
  output logic        [SEL_MUX_TR_WIDTH-1:0] sel_mux_tr_o,
  output logic signed [I_WIDTH+F_WIDTH-1:0]  tr_data_o [N_CH],
  output logic                               valid_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output state_t                             state_o
);

  localparam logic [SEL_MUX_TR_WIDTH-1:0] LAST_SEL = SEL_MUX_TR_WIDTH'(LEN_TRANSFER - 1);

  state_t                 state, state_n;
  logic                   load_sel, load_cnt, step;
  logic                   sel_ok;
  logic [CNT_WIDTH-1:0]   remaining;

  // Handshake: a beat transfers on a rising clk_i where valid_o && ready_i;
  // valid_o is high for the whole RUN state and the index/data stay frozen
  // until that beat is taken, unless abort_i drops the burst first.

`ifdef TR_MUX_RANGE_CHECK_EN
  logic err_q;
  logic err_set;

  assign sel_ok  = (sel_mux_tr_i <= LAST_SEL);
  assign err_set = (state == ST_IDLE) && (start_i || sel_mux_tr_ld_i) && !sel_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign sel_ok = 1'b1;
  assign err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    load_sel = 1'b0;
    load_cnt = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A start, even a rejected one, shadows a same-cycle static load.
        if (start_i) begin
          if (sel_ok) begin
            if (len_i != '0) begin
              load_sel = 1'b1;
              load_cnt = 1'b1;
              state_n  = ST_RUN;
            end else begin
              state_n  = ST_DONE;
            end
          end
        end else if (sel_mux_tr_ld_i && sel_ok) begin
          load_sel = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_n = ST_IDLE;
        end else if (ready_i) begin
          if (remaining == CNT_WIDTH'(1)) begin
            state_n = ST_DONE;
          end else begin
            step = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  tr_mux_sel_ctr #(
    .SEL_W (SEL_MUX_TR_WIDTH),
    .CNT_W (CNT_WIDTH),
    .LEN   (LEN_TRANSFER)
  ) u_sel_ctr (
    .clk       (clk_i),
    .rst       (rst_i),
    .load_sel  (load_sel),
    .load_cnt  (load_cnt),
    .step      (step),
    .sel_in    (sel_mux_tr_i),
    .len_in    (len_i),
    .sel       (sel_mux_tr_o),
    .remaining (remaining)
  );

  assign valid_o = (state == ST_RUN);
  assign busy_o  = (state != ST_IDLE);
  assign done_o  = (state == ST_DONE);
  assign state_o = state;

  // Out-of-range select reads as zero on every channel.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    assign tr_data_o[ch] = (sel_mux_tr_o <= LAST_SEL) ? tr_data_i[ch][sel_mux_tr_o] : '0;
  end

endmodule

// File: tb/tb_tr_mux_seq.sv
// Self-checking bench for tr_mux_seq: directed scenarios plus randomized bursts vs a behavioural model.
module tb_tr_mux_seq;
  import tr_mux_pkg::*;

  localparam int LEN = LEN_TRANSFER;
  localparam int SW  = SEL_MUX_TR_WIDTH;
  localparam int CW  = CNT_WIDTH;
  localparam int NC  = N_CH;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  data_t         tr_data [NC][LEN];
  logic [SW-1:0] sel_in;
  logic          ld, start, abort, ready;
  logic [CW-1:0] len;

  logic [SW-1:0] sel_o;
  data_t         data_o [NC];
  logic          valid_o, busy_o, done_o, err_o;
  state_t        state_o;

  tr_mux_seq dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .tr_data_i       (tr_data),
    .sel_mux_tr_i    (sel_in),
    .sel_mux_tr_ld_i (ld),
    .start_i         (start),
    .len_i           (len),
    .abort_i         (abort),
    .ready_i         (ready),
    .sel_mux_tr_o    (sel_o),
    .tr_data_o       (data_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .state_o         (state_o)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural reference model
  int            m_sel, m_left;
  bit            m_run, m_done, m_err, m_live;
  logic [SW-1:0] exp_q [$];

  function automatic bit bad_sel(input int s);
`ifdef TR_MUX_RANGE_CHECK_EN
    return s >= LEN;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_sel = 0; m_left = 0; m_run = 0; m_done = 0; m_err = 0; m_live = 1;
      exp_q.delete();
    end else if (m_live) begin
      if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (abort) begin
          m_run = 0;
          exp_q.delete();
        end else if (ready) begin
          if (m_left == 1) begin
            m_run = 0; m_done = 1;
          end else begin
            m_left--;
            m_sel = (m_sel + 1) % LEN;
          end
        end
      end else if (start) begin
        if (bad_sel(int'(sel_in))) m_err = 1;
        else if (len != 0) begin
          m_sel = int'(sel_in); m_left = int'(len); m_run = 1;
          for (int k = 0; k < int'(len); k++) exp_q.push_back(SW'((int'(sel_in) + k) % LEN));
        end else m_done = 1;
      end else if (ld) begin
        if (bad_sel(int'(sel_in))) m_err = 1;
        else m_sel = int'(sel_in);
      end
    end
  end

  // scoreboard / per-cycle compare
  always @(negedge clk) begin
    if (m_live) begin
      logic [SW-1:0] e;
      check("sel", sel_o, m_sel);
      check("valid", valid_o, m_run);
      check("busy", busy_o, m_run | m_done);
      check("done", done_o, m_done);
      check("err", err_o, m_err);
      for (int ch = 0; ch < NC; ch++) begin
        if (m_sel < LEN) check("data", data_o[ch], tr_data[ch][m_sel]);
        else             check("data_oor", data_o[ch], 0);
      end
      if (valid_o && ready && !abort && !rst) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_idx", sel_o, e);
          for (int ch = 0; ch < NC; ch++) check("beat_data", data_o[ch], tr_data[ch][e]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int ch = 0; ch < NC; ch++)
      for (int i = 0; i < LEN; i++) tr_data[ch][i] = data_t'($urandom);
  endtask

  int got_idx [$];
  int got_done;

  task automatic collect(input int max_cyc, input int stall_beat, input int stall_len,
                         input int abort_beat, input int rst_beat);
    int stall = 0;
    got_idx.delete();
    got_done = 0;
    for (int c = 0; c < max_cyc; c++) begin
      ready = 1'b1; abort = 1'b0; rst = 1'b0;
      if (!busy_o) break;
      if (got_idx.size() == stall_beat && stall < stall_len) begin
        ready = 1'b0; stall++;
      end
      if (got_idx.size() == abort_beat) abort = 1'b1;
      if (got_idx.size() == rst_beat) rst = 1'b1;
      if (done_o) got_done++;
      if (valid_o && ready && !abort && !rst) got_idx.push_back(int'(sel_o));
      tick();
    end
    ready = 1'b1; abort = 1'b0; rst = 1'b0;
    if (busy_o) check("burst_timeout", busy_o, 0);
  endtask

  task automatic start_burst(input int s, input int l, input bit with_ld);
    sel_in = SW'(s); len = CW'(l); start = 1'b1; ld = with_ld;
    tick();
    start = 1'b0; ld = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    sel_in = '0; len = '0;
    randomize_data();
    repeat (3) tick();
    check("rst_sel", sel_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    rst = 1'b0;
    tick();

    // static load
    sel_in = SW'(3); ld = 1'b1;
    tick();
    ld = 1'b0;
    check("ld_sel", sel_o, 3);
    check("ld_valid", valid_o, 0);
    for (int ch = 0; ch < NC; ch++) check("ld_data", data_o[ch], tr_data[ch][3]);

    // wrapping burst 8,9,0,1
    start_burst(8, 4, 1'b0);
    check("wrap_first_valid", valid_o, 1);
    collect(50, -1, 0, -1, -1);
    check("wrap_beats", got_idx.size(), 4);
    if (got_idx.size() == 4) begin
      check("wrap_b0", got_idx[0], 8);
      check("wrap_b1", got_idx[1], 9);
      check("wrap_b2", got_idx[2], 0);
      check("wrap_b3", got_idx[3], 1);
    end
    check("wrap_done", got_done, 1);
    check("wrap_sel_end", sel_o, 1);

    // backpressure at beat 2
    randomize_data();
    start_burst(2, 3, 1'b0);
    collect(50, 1, 2, -1, -1);
    check("bp_beats", got_idx.size(), 3);
    if (got_idx.size() == 3) check("bp_b2", got_idx[2], 4);
    check("bp_done", got_done, 1);

    // len = 0
    start_burst(7, 0, 1'b0);
    check("len0_done", done_o, 1);
    check("len0_valid", valid_o, 0);
    check("len0_sel", sel_o, 4);
    collect(10, -1, 0, -1, -1);
    check("len0_beats", got_idx.size(), 0);
    check("len0_done_cnt", got_done, 1);
    check("len0_done_after", done_o, 0);

    // start and load together
    start_burst(5, 2, 1'b1);
    check("stld_sel", sel_o, 5);
    collect(20, -1, 0, -1, -1);
    check("stld_beats", got_idx.size(), 2);
    if (got_idx.size() == 2) check("stld_b1", got_idx[1], 6);

    // abort at beat 2 of 5
    start_burst(0, 5, 1'b0);
    collect(20, -1, 0, 1, -1);
    check("abort_beats", got_idx.size(), 1);
    check("abort_done", got_done, 0);
    check("abort_busy", busy_o, 0);
    check("abort_sel", sel_o, 1);

    // reset mid-burst
    start_burst(3, 5, 1'b0);
    collect(20, -1, 0, -1, 2);
    check("rstm_beats", got_idx.size(), 2);
    check("rstm_done", got_done, 0);
    check("rstm_sel", sel_o, 0);
    check("rstm_valid", valid_o, 0);
    check("rstm_busy", busy_o, 0);
    check("rstm_done_o", done_o, 0);

    // out-of-range select
    sel_in = SW'(12); ld = 1'b1;
    tick();
    ld = 1'b0;
`ifdef TR_MUX_RANGE_CHECK_EN
    check("oor_sel", sel_o, 0);
    check("oor_err", err_o, 1);
    start_burst(12, 3, 1'b0);
    check("oor_start_busy", busy_o, 0);
    tick();
    check("oor_err_sticky", err_o, 1);
`else
    check("oor_sel", sel_o, 12);
    for (int ch = 0; ch < NC; ch++) check("oor_data", data_o[ch], 0);
    check("oor_err", err_o, 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) randomize_data();
      if ($urandom_range(0, 9) < 3) begin
        sel_in = SW'($urandom_range(0, (1 << SW) - 1)); ld = 1'b1;
        tick();
        ld = 1'b0;
      end else begin
        start_burst($urandom_range(0, LEN - 1), $urandom_range(0, 25), 1'(($urandom_range(0, 1))));
        for (int c = 0; c < 300; c++) begin
          if (!busy_o) break;
          ready  = ($urandom_range(0, 3) != 0);
          abort  = ($urandom_range(0, 40) == 0);
          start  = 1'($urandom_range(0, 1));
          ld     = 1'($urandom_range(0, 1));
          sel_in = SW'($urandom_range(0, (1 << SW) - 1));
          len    = CW'($urandom_range(0, 25));
          tick();
        end
        ready = 1'b1; abort = 1'b0; start = 1'b0; ld = 1'b0;
        if (busy_o) check("rand_timeout", busy_o, 0);
      end
    end
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
